mapa_grid: RTL and testbench

Parametrised game-map tile memory for the snake game. It holds one CELL_BITS code per cell. It serves three ports: a registered render read port for the VGA renderer, an update read/write port for game logic, and a built-in clear engine. The clear engine sweeps the whole grid to EMPTY (optionally with an obstacle border) after reset or on request. It sits between the game-logic FSM and the VGA renderer.

---
 rtl/mapa_pkg.sv | 17 +
 rtl/mapa_color_decode.sv | 38 +++
 rtl/mapa_grid.sv | 175 +++++++++++++++++
 tb/tb_mapa_grid.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mapa_pkg.sv
// Shared definitions for the snake-game tile map.
//   - Cell code constants stored in each grid cell.
//   - State encoding of the clear engine FSM.
package mapa_pkg;

    localparam int unsigned CELL_EMPTY    = 0;
    localparam int unsigned CELL_SNAKE    = 1;
    localparam int unsigned CELL_FRUIT    = 2;
    localparam int unsigned CELL_OBSTACLE = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StDone  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/mapa_color_decode.sv
// Combinational cell code -> RGB decode for the renderer.
//   cell_i : cell code from the render register
//   r_o    : red channel   (FRUIT, or any code above OBSTACLE)
//   g_o    : green channel (SNAKE, or any code above OBSTACLE)
//   b_o    : blue channel  (OBSTACLE, or any code above OBSTACLE)
module mapa_color_decode
    import mapa_pkg::*;
#(
    parameter int unsigned CELL_BITS  = 2,
    parameter int unsigned COLOR_BITS = 2
) (
    input  logic [CELL_BITS-1:0]  cell_i,
    output logic [COLOR_BITS-1:0] r_o,
    output logic [COLOR_BITS-1:0] g_o,
    output logic [COLOR_BITS-1:0] b_o
);

    logic [31:0] code;

    always_comb begin
        code = 32'(cell_i);
        r_o  = '0;
        g_o  = '0;
        b_o  = '0;
        if (code > CELL_OBSTACLE) begin
            r_o = '1;
            g_o = '1;
            b_o = '1;
        end else if (code == CELL_SNAKE) begin
            g_o = '1;
        end else if (code == CELL_FRUIT) begin
            r_o = '1;
        end else if (code == CELL_OBSTACLE) begin
            b_o = '1;
        end
    end

endmodule

// File: rtl/mapa_grid.sv
// Game-map tile memory: one CELL_BITS code per (x, y) cell.
//   clk, reset              : clock, asynchronous active-low reset
//   vga_read, renderer_rx/ry: registered render read, decoded to mapa_R/G/B
//   update_renable, _rx/_ry : logic read; update_rdata with update_rvalid pulse
//   update_wenable, _wx/_wy : logic write of update_wdata (ignored while busy)
//   clear_start             : sweep the whole grid to EMPTY (or border OBSTACLE)
//   busy, clear_done        : clear engine active / completion pulse
module mapa_grid
    import mapa_pkg::*;
#(
    parameter int unsigned MAPA_WIDTH        = 40,
    parameter int unsigned MAPA_HEIGHT       = 30,
    parameter int unsigned COORD_BITS        = 10,
    parameter int unsigned CELL_BITS         = 2,
    parameter int unsigned COLOR_BITS        = 2,
    parameter int unsigned CLEAR_WITH_BORDER = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vga_read,
    input  logic [COORD_BITS-1:0] renderer_rx,
    input  logic [COORD_BITS-1:0] renderer_ry,
    output logic [COLOR_BITS-1:0] mapa_R,
    output logic [COLOR_BITS-1:0] mapa_G,
    output logic [COLOR_BITS-1:0] mapa_B,
    input  logic                  update_renable,
    input  logic [COORD_BITS-1:0] update_rx,
    input  logic [COORD_BITS-1:0] update_ry,
    output logic [CELL_BITS-1:0]  update_rdata,
    output logic                  update_rvalid,
    input  logic                  update_wenable,
    input  logic [COORD_BITS-1:0] update_wx,
    input  logic [COORD_BITS-1:0] update_wy,
    input  logic [CELL_BITS-1:0]  update_wdata,
    input  logic                  clear_start,
    output logic                  busy,
    output logic                  clear_done
);

    localparam int unsigned XW = (MAPA_WIDTH > 1) ? $clog2(MAPA_WIDTH) : 1;
    localparam int unsigned YW = (MAPA_HEIGHT > 1) ? $clog2(MAPA_HEIGHT) : 1;

    logic [CELL_BITS-1:0] mem_q [MAPA_HEIGHT][MAPA_WIDTH];

    clr_state_e     state_q, state_d;
    logic [XW-1:0]  cx_q, cx_d;
    logic [YW-1:0]  cy_q, cy_d;

    logic                 last_cell;
    logic                 on_border;
    logic                 wr_en;
    logic [XW-1:0]        wr_x;
    logic [YW-1:0]        wr_y;
    logic [CELL_BITS-1:0] wr_data;

    logic                 rnd_in, upd_r_in, upd_w_in;
    logic [CELL_BITS-1:0] rnd_cell, upd_cell;
    logic [CELL_BITS-1:0] render_q;
    logic [CELL_BITS-1:0] rdata_q;
    logic                 rvalid_q;

    assign last_cell = (cx_q == XW'(MAPA_WIDTH - 1)) && (cy_q == YW'(MAPA_HEIGHT - 1));
    assign on_border = (CLEAR_WITH_BORDER != 0) &&
                       ((cx_q == '0) || (cx_q == XW'(MAPA_WIDTH - 1)) ||
                        (cy_q == '0) || (cy_q == YW'(MAPA_HEIGHT - 1)));

    // Reset lands in CLEAR so a full sweep starts as soon as reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StClear;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        unique case (state_q)
            StIdle: begin
                if (clear_start) begin
                    state_d = StClear;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            StClear: begin
                if (last_cell) begin
                    state_d = StDone;
                end else if (cx_q == XW'(MAPA_WIDTH - 1)) begin
                    cx_d = '0;
                    cy_d = cy_q + 1'b1;
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The clear sweep owns the write port; logic writes only get through in IDLE.
    always_comb begin
        busy       = (state_q != StIdle);
        clear_done = (state_q == StDone);
        wr_en      = 1'b0;
        wr_x       = update_wx[XW-1:0];
        wr_y       = update_wy[YW-1:0];
        wr_data    = update_wdata;
        if (state_q == StClear) begin
            wr_en   = 1'b1;
            wr_x    = cx_q;
            wr_y    = cy_q;
            wr_data = on_border ? CELL_BITS'(CELL_OBSTACLE) : CELL_BITS'(CELL_EMPTY);
        end else if ((state_q == StIdle) && update_wenable && upd_w_in) begin
            wr_en = 1'b1;
        end
    end

    assign upd_w_in = (update_wx < COORD_BITS'(MAPA_WIDTH)) &&
                      (update_wy < COORD_BITS'(MAPA_HEIGHT));
    assign rnd_in   = (renderer_rx < COORD_BITS'(MAPA_WIDTH)) &&
                      (renderer_ry < COORD_BITS'(MAPA_HEIGHT));
    assign upd_r_in = (update_rx < COORD_BITS'(MAPA_WIDTH)) &&
                      (update_ry < COORD_BITS'(MAPA_HEIGHT));

    // Truncated indices are only used when the coordinate is in range.
    assign rnd_cell = rnd_in ? mem_q[renderer_ry[YW-1:0]][renderer_rx[XW-1:0]]
                             : CELL_BITS'(CELL_EMPTY);
    assign upd_cell = upd_r_in ? mem_q[update_ry[YW-1:0]][update_rx[XW-1:0]]
                               : CELL_BITS'(CELL_EMPTY);

    // Contents are deliberately not reset; the clear sweep initialises them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_y][wr_x] <= wr_data;
        end
    end

    // Reads sample the pre-write contents, giving read-before-write on collisions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            render_q <= CELL_BITS'(CELL_EMPTY);
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (vga_read) begin
                render_q <= rnd_cell;
            end
            if (update_renable) begin
                rdata_q <= upd_cell;
            end
            rvalid_q <= update_renable;
        end
    end

    assign update_rdata  = rdata_q;
    assign update_rvalid = rvalid_q;

    mapa_color_decode #(
        .CELL_BITS  (CELL_BITS),
        .COLOR_BITS (COLOR_BITS)
    ) u_color_decode (
        .cell_i (render_q),
        .r_o    (mapa_R),
        .g_o    (mapa_G),
        .b_o    (mapa_B)
    );

endmodule

// File: tb/tb_mapa_grid.sv
// Directed bench for mapa_grid: two 4x3 instances sharing inputs, one plain
// clear (dut_a) and one with an obstacle border (dut_b).
module tb_mapa_grid;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned CB = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          vga_read;
    logic [CB-1:0] renderer_rx, renderer_ry;
    logic          update_renable;
    logic [CB-1:0] update_rx, update_ry;
    logic          update_wenable;
    logic [CB-1:0] update_wx, update_wy;
    logic [1:0]    update_wdata;
    logic          clear_start;

    logic [1:0] a_r, a_g, a_b, a_rdata;
    logic       a_rvalid, a_busy, a_done;
    logic [1:0] b_r, b_g, b_b, b_rdata;
    logic       b_rvalid, b_busy, b_done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mapa_grid #(
        .MAPA_WIDTH(W), .MAPA_HEIGHT(H), .COORD_BITS(CB), .CELL_BITS(2),
        .COLOR_BITS(2), .CLEAR_WITH_BORDER(0)
    ) dut_a (
        .clk(clk), .reset(reset), .vga_read(vga_read),
        .renderer_rx(renderer_rx), .renderer_ry(renderer_ry),
        .mapa_R(a_r), .mapa_G(a_g), .mapa_B(a_b),
        .update_renable(update_renable), .update_rx(update_rx), .update_ry(update_ry),
        .update_rdata(a_rdata), .update_rvalid(a_rvalid),
        .update_wenable(update_wenable), .update_wx(update_wx), .update_wy(update_wy),
        .update_wdata(update_wdata), .clear_start(clear_start),
        .busy(a_busy), .clear_done(a_done)
    );

    mapa_grid #(
        .MAPA_WIDTH(W), .MAPA_HEIGHT(H), .COORD_BITS(CB), .CELL_BITS(2),
        .COLOR_BITS(2), .CLEAR_WITH_BORDER(1)
    ) dut_b (
        .clk(clk), .reset(reset), .vga_read(vga_read),
        .renderer_rx(renderer_rx), .renderer_ry(renderer_ry),
        .mapa_R(b_r), .mapa_G(b_g), .mapa_B(b_b),
        .update_renable(update_renable), .update_rx(update_rx), .update_ry(update_ry),
        .update_rdata(b_rdata), .update_rvalid(b_rvalid),
        .update_wenable(update_wenable), .update_wx(update_wx), .update_wy(update_wy),
        .update_wdata(update_wdata), .clear_start(clear_start),
        .busy(b_busy), .clear_done(b_done)
    );

    typedef struct {
        logic ren; int rx; int ry;
        logic wen; int wx; int wy; int wd;
        logic vga; int vx; int vy;
        int e_rdata; int e_rvalid; int e_r; int e_g; int e_b;
    } vec_t;

    vec_t vecs [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        vga_read       = 1'b0;
        update_renable = 1'b0;
        update_wenable = 1'b0;
        clear_start    = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        update_renable = v.ren;
        update_rx      = CB'(v.rx);
        update_ry      = CB'(v.ry);
        update_wenable = v.wen;
        update_wx      = CB'(v.wx);
        update_wy      = CB'(v.wy);
        update_wdata   = 2'(v.wd);
        vga_read       = v.vga;
        renderer_rx    = CB'(v.vx);
        renderer_ry    = CB'(v.vy);
        clear_start    = 1'b0;
    endtask

    // Update read (and render read) of one cell on dut_a or dut_b.
    task automatic read_cell(input int x, input int y, input bit use_b, input int exp,
                             input string nm);
        update_renable = 1'b1;
        update_rx      = CB'(x);
        update_ry      = CB'(y);
        vga_read       = 1'b1;
        renderer_rx    = CB'(x);
        renderer_ry    = CB'(y);
        tick();
        idle_inputs();
        if (use_b) begin
            chk({nm, " b rdata"}, int'(b_rdata), exp);
            chk({nm, " b rvalid"}, int'(b_rvalid), 1);
        end else begin
            chk({nm, " a rdata"}, int'(a_rdata), exp);
            chk({nm, " a rvalid"}, int'(a_rvalid), 1);
            chk({nm, " a rgb"}, int'({a_r, a_g, a_b}),
                (exp == 1) ? 6'b001100 : (exp == 2) ? 6'b110000 :
                (exp == 3) ? 6'b000011 : 0);
        end
    endtask

    // Counts sweep edges after the clear engine enters CLEAR.
    task automatic expect_sweep(input string nm);
        for (int i = 1; i <= int'(W * H); i++) begin
            tick();
            chk($sformatf("%s busy e%0d", nm, i), int'(a_busy), 1);
            chk($sformatf("%s done e%0d", nm, i), int'(a_done), (i == int'(W * H)) ? 1 : 0);
        end
        tick();
        chk({nm, " busy after done"}, int'(a_busy), 0);
        chk({nm, " done after done"}, int'(a_done), 0);
    endtask

    initial begin
        // in: ren rx ry wen wx wy wd vga vx vy | exp: rdata rvalid R G B
        vecs[0]  = '{0, 0, 0, 1, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 2, 1, 0, 0, 0, 0, 1, 2, 1, 2, 1, 3, 0, 0};
        vecs[2]  = '{1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0};
        vecs[4]  = '{0, 0, 0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 3, 0, 0};
        vecs[5]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 1, 3, 0, 0};
        vecs[6]  = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 3, 0};
        vecs[7]  = '{0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 1, 0, 0, 3, 0};
        vecs[8]  = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 1, 0, 0, 3};
        vecs[9]  = '{0, 0, 0, 1, 4, 0, 1, 0, 0, 0, 3, 0, 0, 0, 3};
        vecs[10] = '{0, 0, 0, 1, 40, 0, 2, 0, 0, 0, 3, 0, 0, 0, 3};
        vecs[11] = '{1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 1, 0, 0, 0};
        vecs[12] = '{1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[13] = '{0, 0, 0, 1, 1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[14] = '{1, 1, 1, 0, 0, 0, 0, 1, 2, 1, 1, 1, 3, 0, 0};
        vecs[15] = '{1, 6, 1, 0, 0, 0, 0, 1, 6, 1, 0, 1, 0, 0, 0};

        reset = 1'b0;
        idle_inputs();
        renderer_rx = '0; renderer_ry = '0;
        update_rx = '0; update_ry = '0;
        update_wx = '0; update_wy = '0; update_wdata = '0;

        // Reset state
        tick();
        tick();
        chk("rst busy", int'(a_busy), 1);
        chk("rst done", int'(a_done), 0);
        chk("rst rvalid", int'(a_rvalid), 0);
        chk("rst rdata", int'(a_rdata), 0);
        chk("rst rgb", int'({a_r, a_g, a_b}), 0);

        // Automatic clear after release: W*H sweep edges, done seen at the next edge
        reset = 1'b1;
        expect_sweep("boot");
        for (int y = 0; y < int'(H); y++)
            for (int x = 0; x < int'(W); x++)
                read_cell(x, y, 1'b0, 0, $sformatf("boot cell %0d,%0d", x, y));

        // Directed vectors on dut_a
        foreach (vecs[i]) begin
            drive(vecs[i]);
            tick();
            chk($sformatf("vec%0d rdata", i), int'(a_rdata), vecs[i].e_rdata);
            chk($sformatf("vec%0d rvalid", i), int'(a_rvalid), vecs[i].e_rvalid);
            chk($sformatf("vec%0d R", i), int'(a_r), vecs[i].e_r);
            chk($sformatf("vec%0d G", i), int'(a_g), vecs[i].e_g);
            chk($sformatf("vec%0d B", i), int'(a_b), vecs[i].e_b);
        end
        idle_inputs();

        // Border clear on dut_b; writes and a second start during busy are ignored
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        chk("bclr busy start", int'(b_busy), 1);
        for (int i = 1; i <= int'(W * H); i++) begin
            update_wenable = (i >= 7 && i <= 10);
            update_wx      = CB'(1);
            update_wy      = CB'(1);
            update_wdata   = 2'd2;
            clear_start    = (i == 5);
            tick();
            chk($sformatf("bclr done e%0d", i), int'(b_done), (i == int'(W * H)) ? 1 : 0);
        end
        idle_inputs();
        tick();
        chk("bclr busy end", int'(b_busy), 0);
        tick();
        chk("bclr busy stays low", int'(b_busy), 0);
        read_cell(0, 0, 1'b1, 3, "border 0,0");
        read_cell(3, 2, 1'b1, 3, "border 3,2");
        read_cell(1, 0, 1'b1, 3, "border 1,0");
        read_cell(1, 1, 1'b1, 0, "inner 1,1");
        read_cell(2, 1, 1'b1, 0, "inner 2,1");
        read_cell(1, 1, 1'b0, 0, "plain 1,1");

        // Fill with SNAKE, then reset in the middle of a clear
        for (int y = 0; y < int'(H); y++)
            for (int x = 0; x < int'(W); x++) begin
                update_wenable = 1'b1;
                update_wx      = CB'(x);
                update_wy      = CB'(y);
                update_wdata   = 2'd1;
                tick();
            end
        idle_inputs();
        read_cell(2, 2, 1'b0, 1, "fill 2,2");
        clear_start = 1'b1;
        vga_read    = 1'b1;
        renderer_rx = CB'(3);
        renderer_ry = CB'(2);
        tick();
        idle_inputs();
        for (int i = 0; i < 5; i++) tick();
        chk("mid G before reset", int'(a_g), 3);
        chk("mid busy before reset", int'(a_busy), 1);
        reset = 1'b0;
        #1;
        chk("mid busy in reset", int'(a_busy), 1);
        chk("mid rgb in reset", int'({a_r, a_g, a_b}), 0);
        chk("mid rvalid in reset", int'(a_rvalid), 0);
        chk("mid done in reset", int'(a_done), 0);
        tick();
        tick();
        reset = 1'b1;
        expect_sweep("mid");
        for (int y = 0; y < int'(H); y++)
            for (int x = 0; x < int'(W); x++)
                read_cell(x, y, 1'b0, 0, $sformatf("mid cell %0d,%0d", x, y));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
